// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes and the bit-period helper.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Integer truncation is intended: 100 MHz / 115200 gives 868.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-level handshake between a producer and the UART transmitter, plus the serial line.
interface uart_byte_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_busy,
        output tx_done,
        output tx
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses once every CLKS_PER_BIT cycles after restart is released.
// Shared by the transmit and receive paths.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == CntMax) && !restart;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The serial line, busy and done are all registered outputs.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input logic           clk,
    input logic           rst,
    uart_byte_tx_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam bit          HasParity    = (PARITY != PARITY_NONE);
    localparam logic [2:0]  LastStop     = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        bit_tick;
    logic        parity_bit;

    // Counter is held cleared while idle so the start bit gets a full period from accept.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == StIdle),
        .bit_tick(bit_tick)
    );

    assign parity_bit = (PARITY == PARITY_ODD) ? ~^data_q : ^data_q;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_valid && !busy_q) begin
                    data_d  = bus.tx_data;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        if (HasParity) begin
                            state_d = StParity;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d   = StStop;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (bit_idx_q == LastStop) begin
                        state_d   = StIdle;
                        bit_idx_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: five configurations, a line receiver and a byte scoreboard.
module tb_uart_byte_tx;

    localparam int unsigned NDEF  = 868;
    localparam int unsigned NFAST = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned pcyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [7:0]  exp_q [$];
    int unsigned start_cyc, fall_cyc, last_hi;
    logic        last_par;

    logic [7:0]  d    [5];
    logic        v    [5];
    logic        busy [5];
    logic        done [5];
    logic        txl  [5];
    logic [7:0]  pkt  [9] = '{8'hFF, 8'h12, 8'h34, 8'h00, 8'hC8, 8'hFF, 8'hEE, 8'hFF, 8'h38};

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    uart_byte_tx_if bus0 ();
    uart_byte_tx_if bus1 ();
    uart_byte_tx_if bus2 ();
    uart_byte_tx_if bus3 ();
    uart_byte_tx_if bus4 ();

    uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(115200), .PARITY(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(115200), .PARITY(1), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(115200), .PARITY(2), .STOP_BITS(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(115200), .PARITY(0), .STOP_BITS(2))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));
    uart_byte_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus0.tx_data = d[0];
    assign bus0.tx_valid = v[0];
    assign busy[0] = bus0.tx_busy;
    assign done[0] = bus0.tx_done;
    assign txl[0] = bus0.tx;
    assign bus1.tx_data = d[1];
    assign bus1.tx_valid = v[1];
    assign busy[1] = bus1.tx_busy;
    assign done[1] = bus1.tx_done;
    assign txl[1] = bus1.tx;
    assign bus2.tx_data = d[2];
    assign bus2.tx_valid = v[2];
    assign busy[2] = bus2.tx_busy;
    assign done[2] = bus2.tx_done;
    assign txl[2] = bus2.tx;
    assign bus3.tx_data = d[3];
    assign bus3.tx_valid = v[3];
    assign busy[3] = bus3.tx_busy;
    assign done[3] = bus3.tx_done;
    assign txl[3] = bus3.tx;
    assign bus4.tx_data = d[4];
    assign bus4.tx_valid = v[4];
    assign busy[4] = bus4.tx_busy;
    assign done[4] = bus4.tx_done;
    assign txl[4] = bus4.tx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first cycle after accept.
    task automatic send(input int idx, input logic [7:0] b, input bit push);
        d[idx] = b;
        v[idx] = 1'b1;
        if (push) exp_q.push_back(b);
        @(negedge clk);
        v[idx] = 1'b0;
    endtask

    // Decodes one frame at mid-bit and times it; returns one cycle after the done pulse.
    task automatic rx_frame(input int idx, input int unsigned n, input int unsigned par,
                            input int unsigned stops, input string tag);
        int unsigned nb, k, w, hi, bi;
        logic [7:0]  exp, got;
        logic        ebit;
        bit          early_done;
        nb = 9 + ((par != 0) ? 1 : 0) + stops;
        last_par = 1'bx;
        w = 0;
        while (txl[idx] !== 1'b0 && w < 4 * n + 64) begin
            @(negedge clk);
            w++;
        end
        if (txl[idx] !== 1'b0) begin
            check({tag, "_start"}, 32'(txl[idx]), 0);
            return;
        end
        start_cyc = pcyc;
        check({tag, "_busy_rise"}, 32'(busy[idx]), 1);
        check({tag, "_sb"}, 32'(exp_q.size() != 0), 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        k = 1;
        hi = 0;
        got = '0;
        early_done = 1'b0;
        while (busy[idx] === 1'b1 && k <= nb * n + 8) begin
            hi = (txl[idx] === 1'b1) ? hi + 1 : 0;
            if (done[idx] !== 1'b0) early_done = 1'b1;
            if ((k - 1) % n == n / 2 && (k - 1) / n < nb) begin
                bi = (k - 1) / n;
                if (bi == 0) ebit = 1'b0;
                else if (bi <= 8) ebit = exp[bi - 1];
                else if (bi == 9 && par != 0) ebit = (par == 2) ? ~^exp : ^exp;
                else ebit = 1'b1;
                if (bi >= 1 && bi <= 8) got[bi - 1] = txl[idx];
                if (bi == 9 && par != 0) last_par = txl[idx];
                check($sformatf("%s_bit%0d", tag, bi), 32'(txl[idx]), 32'(ebit));
            end
            @(negedge clk);
            k++;
        end
        fall_cyc = pcyc;
        last_hi = hi;
        check({tag, "_len"}, k - 1, nb * n);
        check({tag, "_byte"}, 32'(got), 32'(exp));
        check({tag, "_early_done"}, 32'(early_done), 0);
        check({tag, "_done"}, 32'(done[idx]), 1);
        check({tag, "_tx_idle"}, 32'(txl[idx]), 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done[idx]), 0);
    endtask

    initial begin
        int unsigned bad, w, prev_fall;
        for (int i = 0; i < 5; i++) begin
            d[i] = '0;
            v[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        check("rst_async_tx0", 32'(txl[0]), 1);
        check("rst_async_busy0", 32'(busy[0]), 0);
        check("rst_async_done0", 32'(done[0]), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_tx4", 32'(txl[4]), 1);
        check("rst_hold_busy4", 32'(busy[4]), 0);
        rst = 1'b0;
        @(negedge clk);

        fork
            send(0, 8'hA5, 1'b1);
            rx_frame(0, NDEF, 0, 1, "a5_8n1");
        join
        fork
            send(1, 8'h07, 1'b1);
            rx_frame(1, NDEF, 1, 1, "even07");
        join
        check("par_even_07", 32'(last_par), 1);
        fork
            send(2, 8'h07, 1'b1);
            rx_frame(2, NDEF, 2, 1, "odd07");
        join
        check("par_odd_07", 32'(last_par), 0);
        fork
            send(3, 8'h00, 1'b1);
            rx_frame(3, NDEF, 0, 2, "stop2");
        join
        check("stop2_high", last_hi, 2 * NDEF);

        // A request 100 cycles into a frame must be dropped, not queued.
        fork
            send(4, 8'h11, 1'b1);
            rx_frame(4, NFAST, 0, 1, "coll");
            begin
                repeat (100) @(negedge clk);
                d[4] = 8'h3C;
                v[4] = 1'b1;
                @(negedge clk);
                v[4] = 1'b0;
            end
        join
        bad = 0;
        repeat (3 * NFAST) begin
            if (txl[4] !== 1'b1 || busy[4] !== 1'b0) bad++;
            @(negedge clk);
        end
        check("coll_idle", bad, 0);
        check("coll_sb_empty", exp_q.size(), 0);

        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    send(4, pkt[i], 1'b1);
                    w = 0;
                    while (busy[4] !== 1'b1 && w < 8) begin
                        @(negedge clk);
                        w++;
                    end
                    w = 0;
                    while (busy[4] !== 1'b0 && w < 20 * NFAST) begin
                        @(negedge clk);
                        w++;
                    end
                end
            end
            begin
                prev_fall = 0;
                for (int i = 0; i < 9; i++) begin
                    rx_frame(4, NFAST, 0, 1, $sformatf("pkt%0d", i));
                    if (i > 0) check($sformatf("pkt%0d_gap", i), 32'((start_cyc - prev_fall) <= 3), 1);
                    prev_fall = fall_cyc;
                end
            end
        join
        check("pkt_sb_empty", exp_q.size(), 0);

        // Reset in the middle of data bit 3 (a 0 bit for 0x37).
        send(4, 8'h37, 1'b0);
        repeat (4 * NFAST + 8) @(negedge clk);
        check("rst_pre_tx", 32'(txl[4]), 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tx", 32'(txl[4]), 1);
        check("rst_mid_busy", 32'(busy[4]), 0);
        check("rst_mid_done", 32'(done[4]), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[4] !== 1'b0 || txl[4] !== 1'b1) bad++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done[4] !== 1'b0 || txl[4] !== 1'b1 || busy[4] !== 1'b0) bad++;
        end
        check("rst_no_done", bad, 0);
        fork
            send(4, 8'h5A, 1'b1);
            rx_frame(4, NFAST, 0, 1, "post_rst");
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
